spi_rr_scheduler: RTL and testbench

//   Shares one 16-bit spi_core between NREQ requesters using round-robin arbitration.

---
 rtl/spi_rr_scheduler_if.sv | 30 +++
 rtl/spi_rr_scheduler.sv | 145 ++++++++++++++
 tb/tb_spi_rr_scheduler.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_rr_scheduler_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_rr_scheduler_if : requester and spi_core signals of the scheduler.  Rev 1.0
// ---------------------------------------------------------------------------
interface spi_rr_scheduler_if #(
  parameter int NREQ = 4,
  parameter int DW   = 16
);
  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0]    gnt;
  logic [NREQ-1:0]    done;
  logic [DW-1:0]      rsp_data;
  logic               rsp_err;
  logic               core_start;
  logic [DW-1:0]      core_datain;
  logic               core_busy;
  logic [DW-1:0]      core_dataout;

  modport slave (
    input  req, req_data, core_busy, core_dataout,
    output gnt, done, rsp_data, rsp_err, core_start, core_datain
  );

  modport master (
    output req, req_data, core_busy, core_dataout,
    input  gnt, done, rsp_data, rsp_err, core_start, core_datain
  );
endinterface
`default_nettype wire

// File: rtl/spi_rr_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// spi_rr_scheduler : round-robin sharing of one spi_core among NREQ clients.  Rev 1.0
// ---------------------------------------------------------------------------
module spi_rr_scheduler #(
  parameter int NREQ          = 4,
  parameter int DW            = 16,
  parameter int START_TIMEOUT = 4
) (
  input  logic                clk,
  input  logic                reset,
  spi_rr_scheduler_if.slave   bus
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = $clog2(START_TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_BUSY  = 2'd2
  } state_t;

  state_t          r_state, w_state;
  logic [NREQ-1:0] r_gnt, w_gnt;
  logic [NREQ-1:0] r_done, w_done;
  logic [DW-1:0]   r_rsp_data, w_rsp_data;
  logic            r_rsp_err, w_rsp_err;
  logic            r_core_start, w_core_start;
  logic [DW-1:0]   r_core_datain, w_core_datain;
  logic [TW-1:0]   r_tmo, w_tmo;
  logic [IW-1:0]   r_last, w_last;
  logic [IW-1:0]   r_sel, w_sel;

  logic [NREQ-1:0] w_elig;
  logic            w_found;
  logic [IW-1:0]   w_pick;

  // A requester whose done is pulsing this cycle is excluded from arbitration.
  assign w_elig = bus.req & ~r_done;

  // Scan from farthest to nearest so the nearest eligible index after last wins.
  always_comb begin : arb
    logic [IW:0] idx;
    w_found = 1'b0;
    w_pick  = '0;
    idx     = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = {1'b0, r_last} + (IW+1)'(k);
      if (idx >= (IW+1)'(NREQ))
        idx = idx - (IW+1)'(NREQ);
      if (w_elig[idx[IW-1:0]]) begin
        w_found = 1'b1;
        w_pick  = idx[IW-1:0];
      end
    end
  end

  always_comb begin
    w_state       = r_state;
    w_gnt         = r_gnt;
    w_done        = '0;
    w_rsp_data    = r_rsp_data;
    w_rsp_err     = 1'b0;
    w_core_start  = r_core_start;
    w_core_datain = r_core_datain;
    w_tmo         = r_tmo;
    w_last        = r_last;
    w_sel         = r_sel;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_gnt         = {{(NREQ-1){1'b0}}, 1'b1} << w_pick;
          w_core_datain = bus.req_data[w_pick*DW +: DW];
          w_core_start  = 1'b1;
          w_tmo         = '0;
          w_sel         = w_pick;
          w_state       = S_START;
        end
      end
      S_START: begin
        w_tmo = r_tmo + 1'b1;
        if (bus.core_busy) begin
          w_core_start = 1'b0;
          w_state      = S_BUSY;
        end else if (r_tmo == TW'(START_TIMEOUT - 1)) begin
          // Core never responded: report an error and leave rsp_data untouched.
          w_core_start = 1'b0;
          w_done       = r_gnt;
          w_rsp_err    = 1'b1;
          w_gnt        = '0;
          w_last       = r_sel;
          w_state      = S_IDLE;
        end
      end
      S_BUSY: begin
        w_core_start = 1'b0;
        if (!bus.core_busy) begin
          w_rsp_data = bus.core_dataout;
          w_done     = r_gnt;
          w_gnt      = '0;
          w_last     = r_sel;
          w_state    = S_IDLE;
        end
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_gnt         <= '0;
      r_done        <= '0;
      r_rsp_data    <= '0;
      r_rsp_err     <= 1'b0;
      r_core_start  <= 1'b0;
      r_core_datain <= '0;
      r_tmo         <= '0;
      r_last        <= IW'(NREQ - 1);
      r_sel         <= '0;
    end else begin
      r_state       <= w_state;
      r_gnt         <= w_gnt;
      r_done        <= w_done;
      r_rsp_data    <= w_rsp_data;
      r_rsp_err     <= w_rsp_err;
      r_core_start  <= w_core_start;
      r_core_datain <= w_core_datain;
      r_tmo         <= w_tmo;
      r_last        <= w_last;
      r_sel         <= w_sel;
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.done        = r_done;
  assign bus.rsp_data    = r_rsp_data;
  assign bus.rsp_err     = r_rsp_err;
  assign bus.core_start  = r_core_start;
  assign bus.core_datain = r_core_datain;

endmodule
`default_nettype wire

// File: tb/tb_spi_rr_scheduler.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_spi_rr_scheduler : directed bench with a behavioural 16-bit spi_core.  Rev 1.0
// ---------------------------------------------------------------------------
module tb_spi_rr_scheduler;
  localparam int NREQ = 4;
  localparam int DW   = 16;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  spi_rr_scheduler_if #(.NREQ(NREQ), .DW(DW)) bus ();

  spi_rr_scheduler #(.NREQ(NREQ), .DW(DW), .START_TIMEOUT(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Core model: busy rises the edge after start, falls 33 cycles later;
  // MISO word is the MOSI word with its nibbles reversed.
  logic        busy_m;
  logic [5:0]  ccnt;
  logic [15:0] mosi_word, dout;
  logic        core_dead = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      busy_m <= 1'b0;
      ccnt   <= '0;
      dout   <= '0;
    end else if (!busy_m) begin
      if (bus.core_start && !core_dead) begin
        busy_m    <= 1'b1;
        ccnt      <= 6'd32;
        mosi_word <= bus.core_datain;
      end
    end else if (ccnt == 0) begin
      busy_m <= 1'b0;
      dout   <= {mosi_word[3:0], mosi_word[7:4], mosi_word[11:8], mosi_word[15:12]};
    end else begin
      ccnt <= ccnt - 1'b1;
    end
  end

  assign bus.core_busy    = busy_m & ~core_dead;
  assign bus.core_dataout = dout;

  int checks_total  = 0;
  int checks_passed = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_total++;
    if (obs === exp) checks_passed++;
    else $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input int i, input logic [15:0] w);
    bus.req_data[i*DW +: DW] = w;
  endtask

  task automatic wait_gnt(output int n);
    n = 0;
    while (bus.gnt == 0 && n < 50) begin
      tick();
      n++;
    end
    check("gnt_seen", 32'(bus.gnt != 0), 32'd1);
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (bus.done == 0 && n < 60) begin
      tick();
      n++;
    end
    check("done_seen", 32'(bus.done != 0), 32'd1);
  endtask

  logic [15:0] t2_data [4] = '{16'h1357, 16'h2468, 16'h9ABC, 16'hDEF0};
  logic [15:0] t2_rsp  [4] = '{16'h7531, 16'h8642, 16'hCBA9, 16'h0FED};
  int          t2_order[5] = '{0, 1, 2, 3, 0};

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, cnt, dcount;
    bus.req      = '0;
    bus.req_data = '0;
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;

    // Reset state
    check("rst_gnt",    32'(bus.gnt),         32'h0);
    check("rst_done",   32'(bus.done),        32'h0);
    check("rst_rsp",    32'(bus.rsp_data),    32'h0);
    check("rst_err",    32'(bus.rsp_err),     32'h0);
    check("rst_start",  32'(bus.core_start),  32'h0);
    check("rst_datain", 32'(bus.core_datain), 32'h0);

    // 1: single transaction, latency
    set_data(0, 16'hA5C3);
    bus.req = 4'b0001;
    tick();
    check("t1_gnt",   32'(bus.gnt),        32'h1);
    check("t1_start", 32'(bus.core_start), 32'h1);
    wait_done(n);
    check("t1_latency", 32'(n + 1),      32'd36);
    check("t1_done",    32'(bus.done),   32'h1);
    check("t1_rsp",     32'(bus.rsp_data), 32'h3C5A);
    check("t1_err",     32'(bus.rsp_err),  32'h0);
    check("t1_mosi",    32'(mosi_word),    32'hA5C3);
    bus.req = 4'b0000;
    tick();
    check("t1_done_pulse", 32'(bus.done), 32'h0);

    // 2: all requesting, strict rotation from a fresh pointer
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) set_data(i, t2_data[i]);
    bus.req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      wait_gnt(n);
      check("t2_gap",    32'(n),                 32'd1);
      check("t2_gnt",    32'(bus.gnt),           32'(4'b0001 << t2_order[t]));
      check("t2_onehot", 32'($countones(bus.gnt)), 32'd1);
      wait_done(n);
      check("t2_done",   32'(bus.done),          32'(4'b0001 << t2_order[t]));
      check("t2_mosi",   32'(mosi_word),         32'(t2_data[t2_order[t]]));
      check("t2_rsp",    32'(bus.rsp_data),      32'(t2_rsp[t2_order[t]]));
      if (t == 4) bus.req = 4'b0000;
    end
    tick();

    // 3: after requester 2 completes, search wraps past 3 to 0, then 2
    bus.req = 4'b0100;
    wait_gnt(n);
    check("t3_gnt2", 32'(bus.gnt), 32'h4);
    wait_done(n);
    bus.req = 4'b0000;
    tick();
    set_data(0, 16'h0F1E);
    bus.req = 4'b0101;
    wait_gnt(n);
    check("t3_gnt0", 32'(bus.gnt), 32'h1);
    wait_done(n);
    check("t3_rsp0", 32'(bus.rsp_data), 32'hE1F0);
    wait_gnt(n);
    check("t3_gnt2b", 32'(bus.gnt), 32'h4);
    wait_done(n);
    check("t3_rsp2", 32'(bus.rsp_data), 32'hCBA9);
    bus.req = 4'b0000;
    tick();

    // 4: dead core, start timeout
    set_data(1, 16'h5555);
    core_dead = 1'b1;
    bus.req = 4'b0010;
    cnt = 0;
    n = 0;
    while (bus.done == 0 && n < 20) begin
      tick();
      n++;
      if (bus.core_start) cnt++;
    end
    check("t4_start_cycles", 32'(cnt),          32'd4);
    check("t4_done",         32'(bus.done),     32'h2);
    check("t4_err",          32'(bus.rsp_err),  32'h1);
    check("t4_rsp_kept",     32'(bus.rsp_data), 32'hCBA9);
    bus.req = 4'b0000;
    core_dead = 1'b0;
    tick();
    check("t4_err_pulse", 32'(bus.rsp_err), 32'h0);

    // 5: reset in the middle of a shift
    set_data(2, 16'h7777);
    bus.req = 4'b0100;
    wait_gnt(n);
    repeat (10) tick();
    check("t5_busy_gnt", 32'(bus.gnt), 32'h4);
    reset = 1'b1;
    bus.req = 4'b0000;
    tick();
    check("t5_gnt",    32'(bus.gnt),         32'h0);
    check("t5_done",   32'(bus.done),        32'h0);
    check("t5_start",  32'(bus.core_start),  32'h0);
    check("t5_datain", 32'(bus.core_datain), 32'h0);
    check("t5_rsp",    32'(bus.rsp_data),    32'h0);
    reset = 1'b0;
    dcount = 0;
    repeat (40) begin
      tick();
      if (bus.done != 0) dcount++;
    end
    check("t5_no_done", 32'(dcount), 32'd0);
    set_data(0, 16'hC0DE);
    set_data(3, 16'h8421);
    bus.req = 4'b1001;
    wait_gnt(n);
    check("t5_gnt0", 32'(bus.gnt), 32'h1);
    wait_done(n);
    check("t5_rsp0", 32'(bus.rsp_data), 32'hED0C);
    wait_gnt(n);
    check("t5_gnt3", 32'(bus.gnt), 32'h8);
    wait_done(n);
    check("t5_rsp3", 32'(bus.rsp_data), 32'h1248);
    bus.req = 4'b0000;
    tick();

    // 6: request dropped mid-transaction, re-raised in its done cycle
    set_data(1, 16'hBEEF);
    bus.req = 4'b0010;
    wait_gnt(n);
    check("t6_gnt", 32'(bus.gnt), 32'h2);
    repeat (5) tick();
    bus.req = 4'b0000;
    wait_done(n);
    check("t6_done", 32'(bus.done),     32'h2);
    check("t6_rsp",  32'(bus.rsp_data), 32'hFEEB);
    bus.req = 4'b0010;
    tick();
    check("t6_no_regrant", 32'(bus.gnt), 32'h0);
    tick();
    check("t6_regrant",    32'(bus.gnt), 32'h2);
    wait_done(n);
    bus.req = 4'b0000;
    tick();

    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
`default_nettype wire
